psram_target: RTL and testbench
===============================

PSRAM_TARGET -- requirements
Module: psram_target

Interface
REQ-001 Parameter DEPTH, default 1024, memory size in bytes (power of two, at most 2^24).
REQ-002 Parameter LATN, default 8, number of fast-read dummy sck cycles (1..15).
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 clk_i  in  1  system clock; at least 4x the psram_sck_i frequency.
REQ-005 rst_i  in  1  asynchronous active-high reset.
REQ-006 psram_sck_i  in  1  serial clock from the initiator.
REQ-007 psram_ce_i  in  1  chip enable, active low.
REQ-008 psram_io_i  in  8  data lanes from the initiator.
REQ-009 psram_io_o  out  8  data lanes to the initiator.
REQ-010 psram_io_en_o  out  8  per-lane output enable; 1 = drive.
REQ-011 qpi_o  out  1  current mode: 0 = SPI, 1 = QPI.

Function
REQ-012 psram_sck_i, psram_ce_i and psram_io_i SHALL each pass through a 2-flop synchronizer; a rising or falling sck edge is detected by comparing the synchronized value with its previous sample.
REQ-013 Inputs SHALL be sampled on a detected rising sck edge; outputs SHALL update on a detected falling sck edge.
REQ-014 Lane width: 1 bit in SPI mode (input io[0], output io[1]); 4 bits in QPI mode (io[3:0] in both directions). Data SHALL be transferred MSB first.
REQ-015 FSM states: IDLE, INST, ADDR, LATN, RDATA, WDATA, IGNR.
REQ-016 IDLE -> INST on the synchronized falling edge of ce.
REQ-017 INST: shift 8 bits, then decode:
- 0x03 read -> ADDR, no latency.
- 0x0B fast read -> ADDR, LATN cycles of latency.
- 0x02 write -> ADDR.
- 0x35 -> set qpi; go to IGNR.
- 0xF5 -> clear qpi; go to IGNR.
- any other value -> IGNR.
REQ-018 ADDR: shift 24 bits.
- Read commands: go to LATN when latency is nonzero, otherwise to RDATA.
- Write: go to WDATA.
REQ-019 LATN: count LATN rising edges, then go to RDATA. The first data bit SHALL appear on the falling edge after the last dummy rising edge.
REQ-020 RDATA: the memory byte at addr is shifted out. After each byte, addr increments modulo DEPTH, giving unlimited burst length with wrap-around.
REQ-021 WDATA: each complete byte is written to mem[addr modulo DEPTH] and addr then increments. A partial byte at ce rise SHALL be discarded.
REQ-022 psram_io_en_o SHALL be nonzero only in RDATA: 8'h02 in SPI mode, 8'h0F in QPI mode. In all other states it is 0, and psram_io_o is 0.
REQ-023 A synchronized ce rise in any state SHALL return the FSM to IDLE within 1 clk_i. Counters are cleared; memory and qpi are kept.
REQ-024 IGNR ignores all sck edges until ce rises.
REQ-025 Address bits above log2(DEPTH) SHALL be ignored.

Reset
REQ-026 On reset:
- FSM goes to IDLE.
- Shift registers, bit counter, latency counter and addr are cleared to 0.
- qpi_o = 0.
- psram_io_o = 0.
- psram_io_en_o = 0.
- Synchronizers are set to sck = 0, ce = 1.
REQ-027 Memory contents SHALL NOT be reset.
REQ-028 Reset asserted mid-transaction SHALL abort it. After reset release, the FSM waits for a fresh ce falling edge.

Structure
REQ-029 A shared package psram_target_pkg SHALL hold:
- the FSM state enum;
- command constants 0x03, 0x0B, 0x02, 0x35 and 0xF5;
- the SPI/QPI lane-enable constants.
REQ-030 The synchronizer plus edge detector SHALL be one sub-module, psram_target_sync. The memory SHALL be an inferred single-port array inside psram_target.

Verification
REQ-031 SPI write 0x02, addr 0x000010, data 0xA5 0x5A; then read 0x03 from the same addr -> io[1] returns 0xA5 then 0x5A, and io_en = 0x02 only during data.
REQ-032 Fast read 0x0B with LATN = 8 at addr 0x10 -> exactly 8 dummy cycles with io_en = 0, then 0xA5.
REQ-033 Command 0x35, then a QPI write of 0x3C to addr DEPTH-1 followed by 0x77 -> 0x77 lands at addr 0 (wrap). A QPI read returns 0x3C, 0x77 on io[3:0] with io_en = 0x0F, and qpi_o = 1.
REQ-034 ce raised after 4 bits of a write data byte -> memory unchanged; the next transaction decodes correctly.
REQ-035 Unknown command 0xFF followed by 40 sck cycles -> io_en stays 0, and the state is IDLE after ce rises.
REQ-036 rst_i asserted during RDATA -> io_en = 0 and qpi_o = 0 immediately, memory retained, and a subsequent SPI read returns the stored data.

Source files
------------

// File: rtl/psram_target_pkg.sv
// Shared types and constants for the PSRAM target model: FSM states,
// command opcodes, lane enables and the per-edge lane step.
package psram_target_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INST  = 3'd1,
    ST_ADDR  = 3'd2,
    ST_LATN  = 3'd3,
    ST_RDATA = 3'd4,
    ST_WDATA = 3'd5,
    ST_IGNR  = 3'd6
  } state_t;

  localparam logic [7:0] CMD_READ   = 8'h03;
  localparam logic [7:0] CMD_FREAD  = 8'h0B;
  localparam logic [7:0] CMD_WRITE  = 8'h02;
  localparam logic [7:0] CMD_QPI_EN = 8'h35;
  localparam logic [7:0] CMD_QPI_EX = 8'hF5;

  localparam logic [7:0] LANE_EN_SPI = 8'h02;
  localparam logic [7:0] LANE_EN_QPI = 8'h0F;

  localparam logic [4:0] INST_BITS = 5'd8;
  localparam logic [4:0] ADDR_BITS = 5'd24;
  localparam logic [4:0] DATA_BITS = 5'd8;

  // Bits moved per sck edge: one lane in SPI, four in QPI.
  function automatic logic [4:0] lane_step(input logic qpi);
    return qpi ? 5'd4 : 5'd1;
  endfunction

endpackage

// File: rtl/psram_target_sync.sv
// Two-flop synchronizers for the serial bus inputs plus sck/ce edge detection
// against the previous synchronized sample.
module psram_target_sync (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_sck,
  input  logic       i_ce,
  input  logic [7:0] i_io,
  output logic       o_sck_rise,
  output logic       o_sck_fall,
  output logic       o_ce_rise,
  output logic       o_ce_fall,
  output logic [7:0] o_io
);

  logic       r_sck_meta, r_sck_sync, r_sck_prev;
  logic       r_ce_meta,  r_ce_sync,  r_ce_prev;
  logic [7:0] r_io_meta,  r_io_sync;

  // Idle bus levels (sck low, ce high) so reset release never fakes an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sck_meta <= 1'b0;
      r_sck_sync <= 1'b0;
      r_sck_prev <= 1'b0;
      r_ce_meta  <= 1'b1;
      r_ce_sync  <= 1'b1;
      r_ce_prev  <= 1'b1;
      r_io_meta  <= 8'h00;
      r_io_sync  <= 8'h00;
    end else begin
      r_sck_meta <= i_sck;
      r_sck_sync <= r_sck_meta;
      r_sck_prev <= r_sck_sync;
      r_ce_meta  <= i_ce;
      r_ce_sync  <= r_ce_meta;
      r_ce_prev  <= r_ce_sync;
      r_io_meta  <= i_io;
      r_io_sync  <= r_io_meta;
    end
  end

  assign o_sck_rise = r_sck_sync & ~r_sck_prev;
  assign o_sck_fall = ~r_sck_sync & r_sck_prev;
  assign o_ce_rise  = r_ce_sync & ~r_ce_prev;
  assign o_ce_fall  = ~r_ce_sync & r_ce_prev;
  assign o_io       = r_io_sync;

endmodule

// File: rtl/psram_target.sv
// PSRAM target model: SPI/QPI command decoder with read, fast read and write
// into an inferred byte-wide memory, oversampling the serial bus on clk_i.
module psram_target
  import psram_target_pkg::*;
#(
  parameter int DEPTH = 1024,
  parameter int LATN  = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_i,
  output logic [7:0] psram_io_o,
  output logic [7:0] psram_io_en_o,
  output logic       qpi_o
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_LAST = 4'(LATN - 1);
  localparam bit         HAS_LAT  = (LATN != 0);

  logic       w_sck_rise, w_sck_fall, w_ce_rise, w_ce_fall;
  logic [7:0] w_io;
  logic       w_unused_io;

  psram_target_sync u_sync (
    .i_clk      (clk_i),
    .i_rst      (rst_i),
    .i_sck      (psram_sck_i),
    .i_ce       (psram_ce_i),
    .i_io       (psram_io_i),
    .o_sck_rise (w_sck_rise),
    .o_sck_fall (w_sck_fall),
    .o_ce_rise  (w_ce_rise),
    .o_ce_fall  (w_ce_fall),
    .o_io       (w_io)
  );

  assign w_unused_io = ^w_io[7:4];

  state_t      r_state, w_next_state;
  logic [7:0]  r_shift;
  logic [4:0]  r_bitcnt;
  logic [3:0]  r_latcnt;
  logic [23:0] r_addr;
  logic        r_qpi, r_fast, r_write;
  logic [7:0]  r_io_o;
  logic [7:0]  r_mem [DEPTH];

  logic [4:0]    w_bits_next;
  logic [7:0]    w_shift_next;
  logic [23:0]   w_addr_next;
  logic [AW-1:0] w_mem_idx;
  logic [7:0]    w_rbyte, w_rshift;
  logic          w_inst_done, w_addr_done, w_byte_done, w_lat_done;

  assign w_bits_next  = r_bitcnt + lane_step(r_qpi);
  assign w_shift_next = r_qpi ? {r_shift[3:0], w_io[3:0]} : {r_shift[6:0], w_io[0]};
  assign w_addr_next  = r_qpi ? {r_addr[19:0], w_io[3:0]} : {r_addr[22:0], w_io[0]};
  // Upper address bits are carried but never index the array, so wrap is free.
  assign w_mem_idx    = r_addr[AW-1:0];
  assign w_rbyte      = r_mem[w_mem_idx];
  assign w_rshift     = w_rbyte << r_bitcnt[2:0];

  assign w_inst_done = (r_state == ST_INST)  && w_sck_rise && (w_bits_next == INST_BITS);
  assign w_addr_done = (r_state == ST_ADDR)  && w_sck_rise && (w_bits_next == ADDR_BITS);
  assign w_byte_done = (r_state == ST_WDATA) && w_sck_rise && (w_bits_next == DATA_BITS);
  assign w_lat_done  = (r_state == ST_LATN)  && w_sck_rise && (r_latcnt == LAT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    if (w_ce_rise) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (w_ce_fall) w_next_state = ST_INST;
        ST_INST: begin
          if (w_inst_done) begin
            case (w_shift_next)
              CMD_READ, CMD_FREAD, CMD_WRITE: w_next_state = ST_ADDR;
              default:                        w_next_state = ST_IGNR;
            endcase
          end
        end
        ST_ADDR: begin
          if (w_addr_done) begin
            if (r_write)                w_next_state = ST_WDATA;
            else if (r_fast && HAS_LAT) w_next_state = ST_LATN;
            else                        w_next_state = ST_RDATA;
          end
        end
        ST_LATN: if (w_lat_done) w_next_state = ST_RDATA;
        default: w_next_state = r_state;
      endcase
    end
  end

  // Datapath: rising edges shift bus data in, falling edges shift read data out.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_shift  <= 8'h00;
      r_bitcnt <= 5'd0;
      r_latcnt <= 4'd0;
      r_addr   <= 24'h0;
      r_qpi    <= 1'b0;
      r_fast   <= 1'b0;
      r_write  <= 1'b0;
      r_io_o   <= 8'h00;
    end else if (w_ce_rise) begin
      r_shift  <= 8'h00;
      r_bitcnt <= 5'd0;
      r_latcnt <= 4'd0;
      r_addr   <= 24'h0;
      r_fast   <= 1'b0;
      r_write  <= 1'b0;
      r_io_o   <= 8'h00;
    end else begin
      case (r_state)
        ST_INST: begin
          if (w_sck_rise) begin
            r_shift  <= w_shift_next;
            r_bitcnt <= w_inst_done ? 5'd0 : w_bits_next;
            if (w_inst_done) begin
              r_fast  <= (w_shift_next == CMD_FREAD);
              r_write <= (w_shift_next == CMD_WRITE);
              if (w_shift_next == CMD_QPI_EN) r_qpi <= 1'b1;
              if (w_shift_next == CMD_QPI_EX) r_qpi <= 1'b0;
            end
          end
        end
        ST_ADDR: begin
          if (w_sck_rise) begin
            r_addr   <= w_addr_next;
            r_bitcnt <= w_addr_done ? 5'd0 : w_bits_next;
          end
        end
        ST_LATN: begin
          if (w_sck_rise) r_latcnt <= w_lat_done ? 4'd0 : r_latcnt + 4'd1;
        end
        ST_RDATA: begin
          if (w_sck_fall) begin
            r_io_o <= r_qpi ? {4'b0000, w_rshift[7:4]} : {6'b000000, w_rshift[7], 1'b0};
            if (w_bits_next == DATA_BITS) begin
              r_bitcnt <= 5'd0;
              r_addr   <= r_addr + 24'd1;
            end else begin
              r_bitcnt <= w_bits_next;
            end
          end
        end
        ST_WDATA: begin
          if (w_sck_rise) begin
            r_shift <= w_shift_next;
            if (w_byte_done) begin
              r_bitcnt <= 5'd0;
              r_addr   <= r_addr + 24'd1;
            end else begin
              r_bitcnt <= w_bits_next;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Memory has no reset so its contents survive rst_i.
  always_ff @(posedge clk_i) begin
    if (w_byte_done && !w_ce_rise) r_mem[w_mem_idx] <= w_shift_next;
  end

  assign psram_io_en_o = (r_state == ST_RDATA) ? (r_qpi ? LANE_EN_QPI : LANE_EN_SPI) : 8'h00;
  assign psram_io_o    = (r_state == ST_RDATA) ? r_io_o : 8'h00;
  assign qpi_o         = r_qpi;

endmodule

// File: tb/tb_psram_target.sv
// Directed self-checking bench for psram_target acting as a simple
// mode-0 SPI/QPI initiator with sck at 1/12 of clk.
module tb_psram_target;
  import psram_target_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       psram_sck_i = 1'b0;
  logic       psram_ce_i = 1'b1;
  logic [7:0] psram_io_i = 8'h00;
  logic [7:0] psram_io_o;
  logic [7:0] psram_io_en_o;
  logic       qpi_o;

  int checkCount = 0;
  int failCount = 0;

  psram_target #(.DEPTH(1024), .LATN(8)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .psram_sck_i   (psram_sck_i),
    .psram_ce_i    (psram_ce_i),
    .psram_io_i    (psram_io_i),
    .psram_io_o    (psram_io_o),
    .psram_io_en_o (psram_io_en_o),
    .qpi_o         (qpi_o)
  );

  always #5 clk = ~clk;

  // One sck period: drive, sample what the target shows before the rise, pulse sck.
  task automatic sck_cycle(input logic [3:0] din, output logic [7:0] dout, output logic [7:0] den);
    psram_io_i = {4'b0000, din};
    #60;
    dout = psram_io_o;
    den  = psram_io_en_o;
    psram_sck_i = 1'b1;
    #60;
    psram_sck_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic quad, output logic [7:0] enOr);
    logic [7:0] d, e;
    enOr = 8'h00;
    if (quad) begin
      sck_cycle(b[7:4], d, e); enOr |= e;
      sck_cycle(b[3:0], d, e); enOr |= e;
    end else begin
      for (int i = 7; i >= 0; i--) begin
        sck_cycle({3'b000, b[i]}, d, e);
        enOr |= e;
      end
    end
  endtask

  task automatic recv_byte(input logic quad, output logic [7:0] data,
                           output logic [7:0] enOr, output logic [7:0] enAnd);
    logic [7:0] d, e;
    data = 8'h00; enOr = 8'h00; enAnd = 8'hFF;
    for (int i = 0; i < (quad ? 2 : 8); i++) begin
      sck_cycle(4'h0, d, e);
      data = quad ? {data[3:0], d[3:0]} : {data[6:0], d[1]};
      enOr  |= e;
      enAnd &= e;
    end
  endtask

  task automatic send_header(input logic [7:0] cmd, input logic [23:0] addr,
                             input logic quad, output logic [7:0] enOr);
    logic [7:0] e;
    psram_ce_i = 1'b0;
    #60;
    send_byte(cmd, quad, enOr);
    send_byte(addr[23:16], quad, e); enOr |= e;
    send_byte(addr[15:8], quad, e);  enOr |= e;
    send_byte(addr[7:0], quad, e);   enOr |= e;
  endtask

  task automatic ce_release();
    #60;
    psram_ce_i = 1'b1;
    psram_io_i = 8'h00;
    #120;
  endtask

  task automatic test_reset();
    #20;
    checkCount++;
    if (psram_io_en_o !== 8'h00) begin failCount++; $display("[TB] FAIL reset_io_en: got %h want 00", psram_io_en_o); end
    checkCount++;
    if (psram_io_o !== 8'h00) begin failCount++; $display("[TB] FAIL reset_io_o: got %h want 00", psram_io_o); end
    checkCount++;
    if (qpi_o !== 1'b0) begin failCount++; $display("[TB] FAIL reset_qpi: got %b want 0", qpi_o); end
    checkCount++;
    if (dut.r_state !== ST_IDLE) begin failCount++; $display("[TB] FAIL reset_state: got %0d want IDLE", dut.r_state); end
    #30;
    rst = 1'b0;
    #100;
  endtask

  task automatic test_spi_write_read();
    logic [7:0] enOr, enAnd, data, e;
    send_header(8'h02, 24'h000010, 1'b0, enOr);
    send_byte(8'hA5, 1'b0, e);
    send_byte(8'h5A, 1'b0, e);
    ce_release();
    send_header(8'h03, 24'h000010, 1'b0, enOr);
    checkCount++;
    if (enOr !== 8'h00) begin failCount++; $display("[TB] FAIL spi_hdr_en: got %h want 00", enOr); end
    recv_byte(1'b0, data, enOr, enAnd);
    checkCount++;
    if (data !== 8'hA5) begin failCount++; $display("[TB] FAIL spi_rd0: got %h want a5", data); end
    checkCount++;
    if (enOr !== 8'h02 || enAnd !== 8'h02) begin failCount++; $display("[TB] FAIL spi_rd0_en: got or %h and %h want 02", enOr, enAnd); end
    recv_byte(1'b0, data, enOr, enAnd);
    checkCount++;
    if (data !== 8'h5A) begin failCount++; $display("[TB] FAIL spi_rd1: got %h want 5a", data); end
    checkCount++;
    if (enOr !== 8'h02 || enAnd !== 8'h02) begin failCount++; $display("[TB] FAIL spi_rd1_en: got or %h and %h want 02", enOr, enAnd); end
    ce_release();
  endtask

  task automatic test_fast_read();
    logic [7:0] enOr, enAnd, data, d, e, dummyEn;
    send_header(8'h0B, 24'h000010, 1'b0, enOr);
    dummyEn = 8'h00;
    for (int i = 0; i < 8; i++) begin
      sck_cycle(4'h0, d, e);
      dummyEn |= e;
    end
    checkCount++;
    if ((enOr | dummyEn) !== 8'h00) begin failCount++; $display("[TB] FAIL fast_dummy_en: got %h want 00", enOr | dummyEn); end
    recv_byte(1'b0, data, enOr, enAnd);
    checkCount++;
    if (data !== 8'hA5) begin failCount++; $display("[TB] FAIL fast_rd: got %h want a5", data); end
    checkCount++;
    if (enOr !== 8'h02 || enAnd !== 8'h02) begin failCount++; $display("[TB] FAIL fast_rd_en: got or %h and %h want 02", enOr, enAnd); end
    ce_release();
  endtask

  task automatic test_partial_write();
    logic [7:0] enOr, enAnd, data, d, e;
    send_header(8'h02, 24'h000010, 1'b0, enOr);
    for (int i = 0; i < 4; i++) sck_cycle(4'h1, d, e);
    ce_release();
    send_header(8'h03, 24'h000010, 1'b0, enOr);
    recv_byte(1'b0, data, enOr, enAnd);
    checkCount++;
    if (data !== 8'hA5) begin failCount++; $display("[TB] FAIL partial_wr: got %h want a5", data); end
    ce_release();
  endtask

  task automatic test_unknown_cmd();
    logic [7:0] enOr, d, e;
    psram_ce_i = 1'b0;
    #60;
    send_byte(8'hFF, 1'b0, enOr);
    for (int i = 0; i < 40; i++) begin
      sck_cycle(4'hF, d, e);
      enOr |= e;
    end
    checkCount++;
    if (enOr !== 8'h00) begin failCount++; $display("[TB] FAIL unk_en: got %h want 00", enOr); end
    ce_release();
    checkCount++;
    if (dut.r_state !== ST_IDLE) begin failCount++; $display("[TB] FAIL unk_state: got %0d want IDLE", dut.r_state); end
  endtask

  task automatic test_qpi();
    logic [7:0] enOr, enAnd, data, e;
    psram_ce_i = 1'b0;
    #60;
    send_byte(8'h35, 1'b0, e);
    ce_release();
    checkCount++;
    if (qpi_o !== 1'b1) begin failCount++; $display("[TB] FAIL qpi_set: got %b want 1", qpi_o); end
    send_header(8'h02, 24'h0003FF, 1'b1, enOr);
    send_byte(8'h3C, 1'b1, e);
    send_byte(8'h77, 1'b1, e);
    ce_release();
    send_header(8'h03, 24'h0003FF, 1'b1, enOr);
    recv_byte(1'b1, data, enOr, enAnd);
    checkCount++;
    if (data !== 8'h3C) begin failCount++; $display("[TB] FAIL qpi_rd0: got %h want 3c", data); end
    checkCount++;
    if (enOr !== 8'h0F || enAnd !== 8'h0F) begin failCount++; $display("[TB] FAIL qpi_rd0_en: got or %h and %h want 0f", enOr, enAnd); end
    recv_byte(1'b1, data, enOr, enAnd);
    checkCount++;
    if (data !== 8'h77) begin failCount++; $display("[TB] FAIL qpi_wrap_rd: got %h want 77", data); end
    checkCount++;
    if (enOr !== 8'h0F || enAnd !== 8'h0F) begin failCount++; $display("[TB] FAIL qpi_rd1_en: got or %h and %h want 0f", enOr, enAnd); end
    ce_release();
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] enOr, enAnd, data;
    send_header(8'h03, 24'h000010, 1'b1, enOr);
    recv_byte(1'b1, data, enOr, enAnd);
    checkCount++;
    if (data !== 8'hA5) begin failCount++; $display("[TB] FAIL rst_pre_rd: got %h want a5", data); end
    rst = 1'b1;
    #1;
    checkCount++;
    if (psram_io_en_o !== 8'h00) begin failCount++; $display("[TB] FAIL rst_mid_en: got %h want 00", psram_io_en_o); end
    checkCount++;
    if (qpi_o !== 1'b0) begin failCount++; $display("[TB] FAIL rst_mid_qpi: got %b want 0", qpi_o); end
    checkCount++;
    if (psram_io_o !== 8'h00) begin failCount++; $display("[TB] FAIL rst_mid_io: got %h want 00", psram_io_o); end
    #39;
    psram_ce_i = 1'b1;
    #40;
    rst = 1'b0;
    #100;
    send_header(8'h03, 24'h000010, 1'b0, enOr);
    recv_byte(1'b0, data, enOr, enAnd);
    checkCount++;
    if (data !== 8'hA5) begin failCount++; $display("[TB] FAIL rst_post_rd: got %h want a5", data); end
    checkCount++;
    if (enOr !== 8'h02 || enAnd !== 8'h02) begin failCount++; $display("[TB] FAIL rst_post_en: got or %h and %h want 02", enOr, enAnd); end
    ce_release();
  endtask

  initial begin
    #2;
    test_reset();
    test_spi_write_read();
    test_fast_read();
    test_partial_write();
    test_unknown_cmd();
    test_qpi();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
